// File: rtl/snn_step_sequencer_if.sv
// Request/result handshake between the timestep sequencer and the shared LIF neuron datapath.
// The sequencer is the master; the datapath is the slave.
interface snn_step_sequencer_if #(
  parameter int IDX_W = 3
) ();
  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_spike_in;
  logic             res_valid;
  logic             res_fire;

  modport master (
    output upd_valid, upd_idx, upd_spike_in,
    input  upd_ready, res_valid, res_fire
  );

  modport slave (
    input  upd_valid, upd_idx, upd_spike_in,
    output upd_ready, res_valid, res_fire
  );
endinterface

// File: rtl/snn_step_sequencer.sv
// Timestep controller: a prescaler tick starts a sweep of the shared neuron datapath
// over all neurons in index order, and the fire results are committed as one spike vector.
module snn_step_sequencer #(
  parameter int N_NEURONS   = 8,
  parameter int IDX_W       = 3,
  parameter int TICK_PERIOD = 32,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [N_NEURONS-1:0]  in_spikes,
  input  logic                  clr_overrun,
  snn_step_sequencer_if.master  upd,
  output logic [N_NEURONS-1:0]  out_spikes,
  output logic                  spike_strobe,
  output logic                  busy,
  output logic                  overrun,
  output logic [CNT_W-1:0]      step_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [N_NEURONS-1:0] pend_reg, snap_reg, fire_acc_reg;
  logic                 tick, start, last;

  assign tick  = ena && (cnt_reg == CNT_W'(TICK_PERIOD - 1));
  assign start = tick && (state_reg == IDLE);
  assign last  = (idx_reg == IDX_W'(N_NEURONS - 1));

  assign upd.upd_valid    = (state_reg == ISSUE);
  assign upd.upd_idx      = (state_reg == ISSUE) ? idx_reg : '0;
  assign upd.upd_spike_in = (state_reg == ISSUE) && snap_reg[idx_reg];
  assign busy             = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick) state_next = ISSUE;
      ISSUE:   if (upd.upd_ready) state_next = WAIT;
      WAIT:    if (upd.res_valid) state_next = last ? COMMIT : ISSUE;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (ena) begin
      cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  // Spikes arriving on the starting tick go to the next step, never into this snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      snap_reg <= '0;
    end else if (start) begin
      snap_reg <= pend_reg;
      pend_reg <= in_spikes;
    end else begin
      pend_reg <= pend_reg | in_spikes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg      <= '0;
      fire_acc_reg <= '0;
      out_spikes   <= '0;
      step_count   <= '0;
      spike_strobe <= 1'b0;
    end else begin
      spike_strobe <= (state_reg == COMMIT);
      if (start) begin
        idx_reg      <= '0;
        fire_acc_reg <= '0;
      end
      if (state_reg == WAIT && upd.res_valid) begin
        fire_acc_reg[idx_reg] <= upd.res_fire;
        if (!last) idx_reg <= idx_reg + IDX_W'(1);
      end
      if (state_reg == COMMIT) begin
        out_spikes <= fire_acc_reg;
        step_count <= step_count + CNT_W'(1);
      end
    end
  end

  // A dropped tick outranks a simultaneous clear so no overrun goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (tick && state_reg != IDLE) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snn_step_sequencer.sv
// Directed bench for snn_step_sequencer: a 32-cycle instance with a stallable datapath model
// and an 8-cycle instance with a slow datapath to provoke overruns.
module tb_snn_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, ena8;
  logic [7:0] in_spikes;
  logic       clr_overrun, clr8;
  logic [7:0] out_spikes, out_spikes8;
  logic       spike_strobe, strobe8, busy, busy8, overrun, overrun8;
  logic [7:0] step_count, step_count8;

  snn_step_sequencer_if #(.IDX_W(3)) sif ();
  snn_step_sequencer_if #(.IDX_W(3)) sif8 ();

  snn_step_sequencer #(.N_NEURONS(8), .IDX_W(3), .TICK_PERIOD(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_spikes(in_spikes), .clr_overrun(clr_overrun),
    .upd(sif), .out_spikes(out_spikes), .spike_strobe(spike_strobe), .busy(busy),
    .overrun(overrun), .step_count(step_count)
  );

  snn_step_sequencer #(.N_NEURONS(8), .IDX_W(3), .TICK_PERIOD(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena8), .in_spikes(8'h00), .clr_overrun(clr8),
    .upd(sif8), .out_spikes(out_spikes8), .spike_strobe(strobe8), .busy(busy8),
    .overrun(overrun8), .step_count(step_count8)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Datapath model for the main instance: fire = idx[0], result one cycle after transfer.
  logic [7:0]  fire_pat = 8'hAA;
  int          res_cnt, stall_left, stall_seen, stable_bad, seq_n;
  logic [2:0]  res_idx, stall_idx, hold_idx;
  bit          held, hold_spk;
  logic [23:0] seq_word;
  logic [7:0]  spk_vec;

  always @(negedge clk) begin
    if (!rst_n) begin
      res_cnt = 0;
      held = 1'b0;
      sif.res_valid = 1'b0;
      sif.res_fire  = 1'b0;
      sif.upd_ready = 1'b1;
    end else begin
      sif.res_valid = 1'b0;
      sif.res_fire  = 1'b0;
      if (res_cnt > 0) begin
        res_cnt--;
        if (res_cnt == 0) begin
          sif.res_valid = 1'b1;
          sif.res_fire  = fire_pat[res_idx];
        end
      end
      sif.upd_ready = 1'b1;
      if (sif.upd_valid && sif.upd_idx == stall_idx && stall_left > 0) begin
        sif.upd_ready = 1'b0;
        stall_left--;
        stall_seen++;
      end
      if (sif.upd_valid) begin
        if (held && (sif.upd_idx != hold_idx || sif.upd_spike_in != hold_spk)) stable_bad++;
        held     = !sif.upd_ready;
        hold_idx = sif.upd_idx;
        hold_spk = sif.upd_spike_in;
      end
      if (sif.upd_valid && sif.upd_ready) begin
        res_cnt  = 1;
        res_idx  = sif.upd_idx;
        seq_word = {seq_word[20:0], sif.upd_idx};
        seq_n++;
        spk_vec[sif.upd_idx] = spk_vec[sif.upd_idx] | sif.upd_spike_in;
      end
    end
  end

  // Slow datapath for the short-period instance: result four cycles after transfer.
  int         res_cnt8, ord8_bad;
  logic [2:0] exp8;
  int         cyc8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc8 <= 0;
    else        cyc8 <= cyc8 + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      res_cnt8 = 0;
      exp8 = 3'd0;
      sif8.res_valid = 1'b0;
      sif8.res_fire  = 1'b0;
      sif8.upd_ready = 1'b1;
    end else begin
      sif8.res_valid = 1'b0;
      if (res_cnt8 > 0) begin
        res_cnt8--;
        if (res_cnt8 == 0) begin
          sif8.res_valid = 1'b1;
          sif8.res_fire  = 1'b1;
        end
      end
      if (sif8.upd_valid) begin
        if (sif8.upd_idx != exp8) ord8_bad++;
        exp8 = exp8 + 3'd1;
        res_cnt8 = 4;
      end
    end
  end

  task automatic clear_seq();
    seq_n = 0;
    seq_word = '0;
    spk_vec = '0;
  endtask

  task automatic wait_strobe(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spike_strobe && n < lim);
    if (!spike_strobe) chk("strobe_timeout", {31'd0, spike_strobe}, 32'd1);
  endtask

  // Indices 0..7 shifted in three bits at a time, 7 in the low bits.
  localparam logic [23:0] SEQ_OK = 24'h053977;

  initial begin
    int n;
    int busy_seen;
    rst_n = 1'b0; ena = 1'b0; ena8 = 1'b0; in_spikes = 8'h00;
    clr_overrun = 1'b0; clr8 = 1'b0; stall_left = 0; stall_idx = 3'd0;
    clear_seq();
    repeat (3) @(negedge clk);
    chk("rst_out", out_spikes, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_step", step_count, 8'd0);
    chk("rst_valid", sif.upd_valid, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_strobe", spike_strobe, 1'b0);

    // 1: first sweep after reset
    rst_n = 1'b1; ena = 1'b1; ena8 = 1'b1;
    wait_strobe(80, n);
    chk("t1_lat", n, 49);
    chk("t1_out", out_spikes, 8'hAA);
    chk("t1_step", step_count, 8'd1);
    chk("t1_seqn", seq_n, 8);
    chk("t1_seq", seq_word, SEQ_OK);
    chk("t1_spk", spk_vec, 8'h00);
    @(negedge clk);
    chk("t1_strobe_once", spike_strobe, 1'b0);

    // 2: one-cycle spike pulse lands in exactly one step
    clear_seq();
    in_spikes = 8'h05;
    @(negedge clk);
    in_spikes = 8'h00;
    wait_strobe(60, n);
    chk("t2_spk", spk_vec, 8'h05);
    chk("t2_seq", seq_word, SEQ_OK);
    chk("t2_step", step_count, 8'd2);
    clear_seq();
    wait_strobe(60, n);
    chk("t2_spk_next", spk_vec, 8'h00);
    chk("t2_step_next", step_count, 8'd3);

    // 3: ready held low 5 cycles on idx 3
    clear_seq();
    stall_idx = 3'd3; stall_left = 5; stall_seen = 0; stable_bad = 0;
    n = 0;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t3_busy", busy, 1'b1);
    wait_strobe(60, n);
    chk("t3_dur", n, 22);
    chk("t3_stalls", stall_seen, 5);
    chk("t3_stable", stable_bad, 0);
    chk("t3_seqn", seq_n, 8);
    chk("t3_seq", seq_word, SEQ_OK);
    chk("t3_out", out_spikes, 8'hAA);
    chk("t3_step", step_count, 8'd4);

    // 4: short period with slow datapath
    chk("t4_ovr", overrun8, 1'b1);
    chk("t4_steps", {31'd0, step_count8 != 8'd0}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc8 % 8 != 3 && n < 16);
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    chk("t4_clr", overrun8, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cyc8 % 8 == 7 && busy8) && n < 80);
    chk("t4_busy_tick", busy8, 1'b1);
    chk("t4_still_clr", overrun8, 1'b0);
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    chk("t4_set_wins", overrun8, 1'b1);
    chk("t4_order", ord8_bad, 0);

    // 5: reset during WAIT of idx 5
    clear_seq();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(sif.upd_valid && sif.upd_ready && sif.upd_idx == 3'd5) && n < 80);
    chk("t5_found", sif.upd_idx, 3'd5);
    @(negedge clk);
    chk("t5_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", sif.upd_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_out", out_spikes, 8'h00);
    chk("t5_step", step_count, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_seq();
    wait_strobe(80, n);
    chk("t5_lat", n, 49);
    chk("t5_seq", seq_word, SEQ_OK);
    chk("t5_seqn", seq_n, 8);
    chk("t5_step_after", step_count, 8'd1);

    // 6: ena low for 100 cycles freezes the prescaler but keeps pending spikes
    ena = 1'b0;
    clear_seq();
    busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_spikes = (i == 40) ? 8'h90 : 8'h00;
      if (busy) busy_seen++;
    end
    chk("t6_nobusy", busy_seen, 0);
    chk("t6_step_hold", step_count, 8'd1);
    ena = 1'b1;
    wait_strobe(80, n);
    chk("t6_lat", n, 32);
    chk("t6_spk", spk_vec, 8'h90);
    chk("t6_step", step_count, 8'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

endmodule
